// File: rtl/full_adder_cell_if.sv
// Operand/result bundle for full_adder_cell.
// The master drives the operands and capture strobe; the slave (the adder)
// returns the registered sum, carry-out and result-valid flag.
interface full_adder_cell_if #(
  parameter int WIDTH = 1
) ();

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             out_valid;

  modport master (
    output in_valid,
    output a,
    output b,
    output c_in,
    input  sum,
    input  c_out,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  c_in,
    output sum,
    output c_out,
    output out_valid
  );

endinterface

// File: rtl/full_adder_cell.sv
// Registered ripple-carry adder built from 1-bit full-adder cells.
// {c_out, sum} = a + b + c_in (unsigned, modulo 2^(WIDTH+1)), one cycle
// after in_valid is sampled high. With in_valid low the result registers
// hold and only out_valid drops. The carry chain is purely combinational
// into the result register, so there is no input-to-output path.
module full_adder_cell #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  full_adder_cell_if.slave   bus
);

  // One full-adder cell: sum bit.
  function automatic logic fa_sum(input logic x, input logic y, input logic ci);
    return x ^ y ^ ci;
  endfunction

  // One full-adder cell: carry to the next bit (majority of the three inputs).
  function automatic logic fa_carry(input logic x, input logic y, input logic ci);
    return (x & y) | (x & ci) | (y & ci);
  endfunction

  logic [WIDTH:0]   carry_p0;
  logic [WIDTH-1:0] sum_p0;

  logic [WIDTH-1:0] sum_p1;
  logic             cout_p1;
  logic             vld_p1;

  // ---- stage p0: ripple chain of full-adder cells, carry enters at bit 0 ----
  always_comb begin
    carry_p0    = '0;
    sum_p0      = '0;
    carry_p0[0] = bus.c_in;
    for (int i = 0; i < WIDTH; i++) begin
      sum_p0[i]     = fa_sum(bus.a[i], bus.b[i], carry_p0[i]);
      carry_p0[i+1] = fa_carry(bus.a[i], bus.b[i], carry_p0[i]);
    end
  end

  // ---- stage p1: result register, loads only on a valid capture ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_p1  <= '0;
      cout_p1 <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= bus.in_valid;
      if (bus.in_valid) begin
        sum_p1  <= sum_p0;
        cout_p1 <= carry_p0[WIDTH];
      end
    end
  end

  assign bus.sum       = sum_p1;
  assign bus.c_out     = cout_p1;
  assign bus.out_valid = vld_p1;

endmodule

// File: tb/tb_full_adder_cell.sv
// Bench for full_adder_cell at WIDTH=1, 8 and 16 sharing one clock/reset.
// Each cycle the expected {c_out,sum} per instance is pushed to a scoreboard
// when operands are driven and popped when the registered result is due.
module tb_full_adder_cell;

  logic clk;
  logic rst_n;

  full_adder_cell_if #(.WIDTH(1))  if1 ();
  full_adder_cell_if #(.WIDTH(8))  if8 ();
  full_adder_cell_if #(.WIDTH(16)) if16 ();

  full_adder_cell #(.WIDTH(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(if1));
  full_adder_cell #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  full_adder_cell #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

  typedef struct {
    logic        v1;
    logic [1:0]  r1;
    logic        v8;
    logic [8:0]  r8;
    logic        v16;
    logic [16:0] r16;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  logic [1:0]  hold1  = '0;
  logic [8:0]  hold8  = '0;
  logic [16:0] hold16 = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic v1, input logic a1, input logic b1, input logic c1,
                        input logic v8, input logic [7:0] a8, input logic [7:0] b8, input logic c8,
                        input logic v16, input logic [15:0] a16, input logic [15:0] b16,
                        input logic c16);
    if1.in_valid  = v1;  if1.a  = a1;  if1.b  = b1;  if1.c_in  = c1;
    if8.in_valid  = v8;  if8.a  = a8;  if8.b  = b8;  if8.c_in  = c8;
    if16.in_valid = v16; if16.a = a16; if16.b = b16; if16.c_in = c16;
  endtask

  task automatic set_rand();
    set_in(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
           1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
  endtask

  // Push expectations for the operands now on the bus, advance one edge,
  // then pop and compare valid flags and results (held value when idle).
  task automatic tick(input string tag);
    exp_t e;
    e.v1  = rst_n & if1.in_valid;
    e.r1  = 2'(if1.a) + 2'(if1.b) + 2'(if1.c_in);
    e.v8  = rst_n & if8.in_valid;
    e.r8  = 9'(if8.a) + 9'(if8.b) + 9'(if8.c_in);
    e.v16 = rst_n & if16.in_valid;
    e.r16 = 17'(if16.a) + 17'(if16.b) + 17'(if16.c_in);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.v1)  hold1  = e.r1;
    if (e.v8)  hold8  = e.r8;
    if (e.v16) hold16 = e.r16;
    if (!rst_n) begin
      hold1 = '0; hold8 = '0; hold16 = '0;
    end
    chk({tag, "_w1_vld"},  17'(if1.out_valid),  17'(e.v1));
    chk({tag, "_w1_res"},  17'({if1.c_out, if1.sum}),   17'(hold1));
    chk({tag, "_w8_vld"},  17'(if8.out_valid),  17'(e.v8));
    chk({tag, "_w8_res"},  17'({if8.c_out, if8.sum}),   17'(hold8));
    chk({tag, "_w16_vld"}, 17'(if16.out_valid), 17'(e.v16));
    chk({tag, "_w16_res"}, {if16.c_out, if16.sum}, hold16);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_w1"},  17'({if1.out_valid, if1.c_out, if1.sum}),   17'd0);
    chk({tag, "_w8"},  17'({if8.out_valid, if8.c_out, if8.sum}),   17'd0);
    chk({tag, "_w16"}, 17'({if16.c_out, if16.sum}), 17'd0);
    chk({tag, "_w16_vld"}, 17'(if16.out_valid), 17'd0);
  endtask

  initial begin
    logic [2:0] tv;

    // Reset held with all operands high and valid: outputs stay zero.
    rst_n = 1'b0;
    set_in(1'b1, 1'b1, 1'b1, 1'b1,
           1'b1, 8'hFF, 8'hFF, 1'b1,
           1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    #1;
    chk_cleared("rst_t0");
    tick("rst_a");
    tick("rst_b");
    #4;
    rst_n = 1'b1;

    // First edge out of reset captures 1+1+1.
    tick("rel");
    chk("rel_w1_exact", 17'({if1.out_valid, if1.c_out, if1.sum}), 17'b111);

    // WIDTH=1 exhaustive truth table, back-to-back.
    for (int i = 0; i < 8; i++) begin
      set_rand();
      tv = 3'(i);
      if1.in_valid = 1'b1;
      if1.a        = tv[2];
      if1.b        = tv[1];
      if1.c_in     = tv[0];
      tick($sformatf("tt%0d", i));
    end

    // Idle hold: valid drops, last result (1+1+1) stays.
    set_in(1'b0, 1'b0, 1'b0, 1'b0,
           1'b0, 8'h00, 8'h00, 1'b0,
           1'b0, 16'h0000, 16'h0000, 1'b0);
    tick("idle");
    chk("idle_w1_hold", 17'({if1.out_valid, if1.c_out, if1.sum}), 17'b011);

    // Full ripple cases on the 8-bit instance.
    set_in(1'b0, 1'b0, 1'b0, 1'b0,
           1'b1, 8'hFF, 8'h00, 1'b1,
           1'b1, 16'hFFFF, 16'h0000, 1'b1);
    tick("rip_ff");
    chk("rip_ff_w8_exact", 17'({if8.c_out, if8.sum}), 17'h100);
    set_in(1'b0, 1'b0, 1'b0, 1'b0,
           1'b1, 8'h80, 8'h80, 1'b0,
           1'b1, 16'h8000, 16'h8000, 1'b0);
    tick("rip_80");
    chk("rip_80_w8_exact", 17'({if8.c_out, if8.sum}), 17'h100);
    set_in(1'b0, 1'b0, 1'b0, 1'b0,
           1'b1, 8'h55, 8'hAA, 1'b0,
           1'b1, 16'h5555, 16'hAAAA, 1'b0);
    tick("rip_55");
    chk("rip_55_w8_exact", 17'({if8.c_out, if8.sum}), 17'h0FF);

    // Async reset between edges while results are valid.
    set_in(1'b1, 1'b1, 1'b0, 1'b1,
           1'b1, 8'hC3, 8'h5A, 1'b1,
           1'b1, 16'h1234, 16'hF00F, 1'b1);
    tick("pre_ar");
    #4;
    rst_n = 1'b0;
    #1;
    chk_cleared("async_rst");
    hold1 = '0; hold8 = '0; hold16 = '0;
    tick("ar_hold");
    #4;
    rst_n = 1'b1;

    // Random traffic with random in_valid on all widths.
    for (int i = 0; i < 1000; i++) begin
      set_rand();
      tick("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
